// File: rtl/velocity_reader_pkg.sv
// Shared FSM state type and constants for the velocity cell reader and its FIFO.
package velocity_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CNT,
    LATCH_CNT,
    STREAM,
    DRAIN,
    FINISH
  } state_e;

  localparam int COUNT_ADDR = 0;
  localparam int FIFO_DEPTH = 2;

  // Limits the particle count read from word 0 to the last valid memory word.
  function automatic int clampCount(input int raw, input int limit);
    return (raw > limit) ? limit : raw;
  endfunction

endpackage

// File: rtl/velocity_cell_reader_if.sv
// Control, cell-memory and output-stream signals of the velocity cell reader.
interface velocity_cell_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_id;
  logic                  out_last;
  logic [15:0]           stall_cycles;

  modport master (
    input  start,
    output busy,
    output done,
    output mem_address,
    output mem_rden,
    output mem_wren,
    output mem_data,
    input  mem_q,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_id,
    output out_last,
    output stall_cycles
  );

  modport slave (
    output start,
    input  busy,
    input  done,
    input  mem_address,
    input  mem_rden,
    input  mem_wren,
    input  mem_data,
    output mem_q,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_id,
    input  out_last,
    input  stall_cycles
  );

endinterface

// File: rtl/velocity_reader_fifo2.sv
// Two-entry FIFO whose head entry is a register driven straight to the outputs.
module velocity_reader_fifo2
  import velocity_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             doPush;
  logic             doPop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    doPop   = pop_i && (count_q != 2'd0);
    doPush  = push_i && ((count_q != 2'(FIFO_DEPTH)) || doPop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({doPush, doPop})
      2'b10: begin
        if (count_q == 2'd0) head_d = data_i;
        else                 tail_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign data_o  = head_q;
  assign full_o  = (count_q == 2'(FIFO_DEPTH));
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/velocity_cell_reader.sv
// Streams the velocity words of one cell: reads the count in word 0, then words 1..N.
// Optional backpressure counter enabled by defining VELOCITY_READER_STATS_EN.
module velocity_cell_reader
  import velocity_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input logic                    clk,
  input logic                    rst,
  velocity_cell_reader_if.master bus
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cellCount_q, cellCount_d;
  logic [ADDR_WIDTH-1:0] nextAddr_q, nextAddr_d;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflightId_q;
  logic                  inflightLast_q;

  logic [ADDR_WIDTH-1:0] countLatched;
  logic                  memRden;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  issue;
  logic                  pop;
  logic [2:0]            pending;
  logic                  canIssue;

  logic [ENTRY_WIDTH-1:0] fifoIn;
  logic [ENTRY_WIDTH-1:0] fifoHead;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic [1:0]             fifoCount;
  logic                   headLast;

  assign countLatched = ADDR_WIDTH'(clampCount(int'(bus.mem_q[ADDR_WIDTH-1:0]), PARTICLE_NUM - 1));

  // Entries already buffered or on their way back, after this cycle's pop, must leave room for one more.
  assign pop      = !fifoEmpty && bus.out_ready;
  assign pending  = 3'(fifoCount) + 3'(inflight_q) - 3'(pop);
  assign canIssue = (pending < 3'(FIFO_DEPTH)) && !(fifoFull && !pop);

  always_comb begin
    state_d     = state_q;
    cellCount_d = cellCount_q;
    nextAddr_d  = nextAddr_q;
    memRden     = 1'b0;
    memAddr     = nextAddr_q;
    issue       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = RD_CNT;
      end
      RD_CNT: begin
        memRden = 1'b1;
        memAddr = ADDR_WIDTH'(COUNT_ADDR);
        state_d = LATCH_CNT;
      end
      LATCH_CNT: begin
        cellCount_d = countLatched;
        nextAddr_d  = ADDR_WIDTH'(1);
        state_d     = (countLatched == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        if (canIssue) begin
          memRden    = 1'b1;
          issue      = 1'b1;
          nextAddr_d = nextAddr_q + ADDR_WIDTH'(1);
          if (nextAddr_q == cellCount_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && headLast) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cellCount_q    <= '0;
      nextAddr_q     <= '0;
      inflight_q     <= 1'b0;
      inflightId_q   <= '0;
      inflightLast_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cellCount_q    <= cellCount_d;
      nextAddr_q     <= nextAddr_d;
      inflight_q     <= issue;
      inflightId_q   <= nextAddr_q;
      inflightLast_q <= (nextAddr_q == cellCount_q);
    end
  end

  // Each returning word carries the id and last flag recorded when its read was issued.
  assign fifoIn = {inflightLast_q, inflightId_q, bus.mem_q};

  velocity_reader_fifo2 #(
    .WIDTH(ENTRY_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .data_i  (fifoIn),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign headLast = fifoHead[ENTRY_WIDTH-1];

  assign bus.out_valid   = !fifoEmpty;
  assign bus.out_data    = fifoHead[DATA_WIDTH-1:0];
  assign bus.out_id      = fifoHead[DATA_WIDTH +: ADDR_WIDTH];
  assign bus.out_last    = !fifoEmpty && headLast;
  assign bus.mem_rden    = memRden;
  assign bus.mem_address = memAddr;
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_data    = '0;
  assign bus.busy        = (state_q == RD_CNT) || (state_q == LATCH_CNT) ||
                           (state_q == STREAM) || (state_q == DRAIN);
  assign bus.done        = (state_q == FINISH);

`ifdef VELOCITY_READER_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && bus.start) begin
      stall_d = '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_velocity_cell_reader.sv
// Directed bench for velocity_cell_reader: vector table plus reset-mid-stream sequence.
module tb_velocity_cell_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
`ifdef VELOCITY_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [95:0] word0;
    int lowFrom;
    int lowTo;
    int pokeAt;
    int expN;
    int expFirst;
    int expDone;
    int expBusy;
    int expStall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [95:0] word0 = '0;

  int testsRun = 0;
  int failCount = 0;

  int firstValid, beatCount, badBeats, lastId, doneCycle, busyCycles;
  int stableErrs, memConstErrs, readsIssued, maxOut;
  logic [15:0] stallAtDone;
  logic [1:0]  doneAfter;

  velocity_cell_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  velocity_cell_reader #(
    .DATA_WIDTH  (DW),
    .PARTICLE_NUM(PN),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] cellWord(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {32'h3000_0000 + kk, 32'h2000_0000 + kk, 32'h1000_0000 + kk};
  endfunction

  // Memory returns data one cycle after a read; garbage otherwise.
  always @(posedge clk) begin
    if (bus.mem_rden)
      bus.mem_q <= (bus.mem_address == '0) ? word0 : cellWord(int'(bus.mem_address));
    else
      bus.mem_q <= {3{32'hDEAD_BEEF}};
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic          prevValid, prevReady, prevLast;
    logic [95:0]   prevData;
    logic [AW-1:0] prevId;
    word0 = v.word0;
    firstValid = -1; beatCount = 0; badBeats = 0; lastId = 0; doneCycle = -1;
    busyCycles = 0; stableErrs = 0; memConstErrs = 0; readsIssued = 0; maxOut = 0;
    stallAtDone = '0;
    prevValid = 1'b0; prevReady = 1'b1; prevLast = 1'b0; prevData = '0; prevId = '0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= v.lowFrom && cyc <= v.lowTo);
      bus.start     = (cyc == v.pokeAt);
      #1;
      if (bus.mem_wren !== 1'b0 || bus.mem_data !== '0) memConstErrs++;
      if (bus.busy) busyCycles++;
      if (bus.mem_rden && bus.mem_address != '0) readsIssued++;
      if (prevValid && !prevReady) begin
        if (!bus.out_valid || bus.out_data !== prevData || bus.out_id !== prevId || bus.out_last !== prevLast)
          stableErrs++;
      end
      if (bus.out_valid && firstValid < 0) firstValid = cyc;
      if (bus.out_valid && bus.out_ready) begin
        beatCount++;
        if (bus.out_id !== AW'(beatCount) || bus.out_data !== cellWord(beatCount) ||
            bus.out_last !== (beatCount == v.expN))
          badBeats++;
        lastId = int'(bus.out_id);
      end
      if (readsIssued - beatCount > maxOut) maxOut = readsIssued - beatCount;
      prevValid = bus.out_valid; prevReady = bus.out_ready; prevLast = bus.out_last;
      prevData = bus.out_data; prevId = bus.out_id;
      if (bus.done) begin
        doneCycle = cyc;
        stallAtDone = bus.stall_cycles;
        break;
      end
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    doneAfter = {bus.done, bus.busy};
  endtask

  task automatic runVector(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput({tag, "_first_valid"}, firstValid, v.expFirst);
    checkOutput({tag, "_beats"}, beatCount, v.expN);
    checkOutput({tag, "_bad_beats"}, badBeats, 0);
    checkOutput({tag, "_last_id"}, lastId, v.expN);
    checkOutput({tag, "_done_cycle"}, doneCycle, v.expDone);
    checkOutput({tag, "_busy_cycles"}, busyCycles, v.expBusy);
    checkOutput({tag, "_stable_errs"}, stableErrs, 0);
    checkOutput({tag, "_outstanding_gt2"}, maxOut > 2, 0);
    checkOutput({tag, "_mem_const_errs"}, memConstErrs, 0);
    checkOutput({tag, "_stall_cycles"}, stallAtDone, v.expStall);
    checkOutput({tag, "_done_busy_after"}, doneAfter, 2'b00);
  endtask

  vec_t vecs[6];
  vec_t again;
  int   midBeats;

  initial begin
    // N=4 with ready low 5..10; N=3 follows to show the stall counter clears on start.
    vecs[0] = '{96'd4,   5, 10, 0, 4, 5, 15, 14, STATS ? 6 : 0};
    vecs[1] = '{96'd3,   0, -1, 6, 3, 5,  8,  7, 0};
    vecs[2] = '{96'd0,   0, -1, 0, 0, -1, 3,  2, 0};
    vecs[3] = '{96'd5,   6, 12, 0, 5, 5, 17, 16, STATS ? 7 : 0};
    vecs[4] = '{96'hFFFF_FFFF_FFFF_FFFF_FFFF_FF01, 0, -1, 0, 1, 5, 6, 5, 0};
    vecs[5] = '{96'd250, 0, -1, 0, 219, 5, 224, 223, 0};

    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_last", bus.out_last, 1'b0);
    checkOutput("rst_mem_rden", bus.mem_rden, 1'b0);
    checkOutput("rst_out_data", bus.out_data, 96'd0);
    checkOutput("rst_out_id", bus.out_id, 8'd0);
    checkOutput("rst_stall", bus.stall_cycles, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) runVector($sformatf("v%0d", i), vecs[i]);

    // Reset right after the second beat of a 10-word stream.
    word0 = 96'd10;
    midBeats = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk); #1;
      if (bus.out_valid && bus.out_ready) midBeats++;
      if (midBeats == 2) begin
        rst = 1'b1;
        break;
      end
    end
    checkOutput("mid_beats_before_rst", midBeats, 2);
    @(negedge clk); #1;
    checkOutput("mid_rst_busy", bus.busy, 1'b0);
    checkOutput("mid_rst_done", bus.done, 1'b0);
    checkOutput("mid_rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("mid_rst_out_last", bus.out_last, 1'b0);
    checkOutput("mid_rst_mem_rden", bus.mem_rden, 1'b0);
    checkOutput("mid_rst_out_data", bus.out_data, 96'd0);
    checkOutput("mid_rst_out_id", bus.out_id, 8'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("mid_rst_return_dropped", bus.out_valid, 1'b0);

    again = '{96'd3, 0, -1, 0, 3, 5, 8, 7, 0};
    runVector("after_rst", again);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
